// File: rtl/fence_seq_ctrl.sv
// fence_seq_ctrl: commit-stage sequencer for the serialising FU_CSR ops
// (FENCE, FENCE_I, SFENCE_VMA, WFI). Holds the frontend, walks the memory
// system through drain / D-cache writeback / I-cache invalidate / TLB flush
// or wait-for-interrupt, then acks commit, kills younger ops and redirects
// fetch to pc+4.
//
// Build option: define FENCE_SEQ_WFI_NOP_EN to make WFI retire immediately
// (IDLE -> REDIRECT) without waiting for an interrupt.

package fence_seq_ctrl_pkg;

    localparam int unsigned RV_XLEN = 64;

    // Ops decode can hand to the FU_CSR commit path
    typedef enum logic [3:0] {
        NOP        = 4'd0,
        CSRRW      = 4'd1,
        CSRRS      = 4'd2,
        CSRRC      = 4'd3,
        CSRRWI     = 4'd4,
        CSRRSI     = 4'd5,
        CSRRCI     = 4'd6,
        ECALL      = 4'd7,
        EBREAK     = 4'd8,
        MRET       = 4'd9,
        SRET       = 4'd10,
        FENCE      = 4'd11,
        FENCE_I    = 4'd12,
        SFENCE_VMA = 4'd13,
        WFI        = 4'd14
    } fu_op_t;

endpackage

module fence_seq_ctrl
    import fence_seq_ctrl_pkg::*;
#(
    parameter int unsigned DFLUSH_TIMEOUT = 1024,
    parameter int unsigned XLEN           = RV_XLEN
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            commit_valid_i,
    input  fu_op_t          commit_op_i,
    input  logic [XLEN-1:0] commit_pc_i,
    output logic            commit_ack_o,

    output logic            busy_o,
    output logic            halt_fetch_o,

    input  logic            sb_empty_i,

    output logic            dcache_flush_o,
    input  logic            dcache_flush_ack_i,
    output logic            icache_flush_o,
    output logic            tlb_flush_o,

    input  logic            irq_pending_i,

    output logic            flush_pipe_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            flush_err_o
);

    // Counter must hold DFLUSH_TIMEOUT itself; keep at least one bit
    localparam int unsigned      CNT_W     = (DFLUSH_TIMEOUT < 2) ? 1 : $clog2(DFLUSH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DFLUSH_TIMEOUT);
    localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(4);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        DFLUSH   = 3'd2,
        IFLUSH   = 3'd3,
        TLB      = 3'd4,
        WAIT_IRQ = 3'd5,
        REDIRECT = 3'd6
    } state_t;

    state_t           state_q;
    fu_op_t           op_q;
    logic [XLEN-1:0]  pc_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             cnt_expire_c;

    // Only the four serialising ops are taken; everything else passes through untouched
    assign accept_c = commit_valid_i &&
                      (commit_op_i inside {FENCE, FENCE_I, SFENCE_VMA, WFI});

    // DFLUSH gives up once this cycle would be the DFLUSH_TIMEOUT-th without an ack
    assign cnt_inc_c    = cnt_q + CNT_W'(1);
    assign cnt_expire_c = (cnt_inc_c == CNT_LIMIT);

    // Sequencer: state, latched op/pc, timeout counter and all registered outputs.
    // Each output is set on the edge that enters the state owning it, so it is
    // valid for exactly the cycles the FSM spends there.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q          <= IDLE;
            op_q             <= NOP;
            pc_q             <= '0;
            cnt_q            <= '0;
            commit_ack_o     <= 1'b0;
            busy_o           <= 1'b0;
            halt_fetch_o     <= 1'b0;
            dcache_flush_o   <= 1'b0;
            icache_flush_o   <= 1'b0;
            tlb_flush_o      <= 1'b0;
            flush_pipe_o     <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            flush_err_o      <= 1'b0;
        end else begin
            // Single-cycle outputs fall unless the transition below re-arms them
            commit_ack_o     <= 1'b0;
            icache_flush_o   <= 1'b0;
            tlb_flush_o      <= 1'b0;
            flush_pipe_o     <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            flush_err_o      <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        op_q         <= commit_op_i;
                        pc_q         <= commit_pc_i;
                        busy_o       <= 1'b1;
                        halt_fetch_o <= 1'b1;
                        if (commit_op_i == WFI) begin
`ifdef FENCE_SEQ_WFI_NOP_EN
                            state_q          <= REDIRECT;
                            commit_ack_o     <= 1'b1;
                            flush_pipe_o     <= 1'b1;
                            redirect_valid_o <= 1'b1;
                            redirect_pc_o    <= commit_pc_i + PC_STEP;
`else
                            state_q <= WAIT_IRQ;
`endif
                        end else begin
                            state_q <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (sb_empty_i) begin
                        case (op_q)
                            FENCE_I: begin
                                state_q        <= DFLUSH;
                                dcache_flush_o <= 1'b1;
                                cnt_q          <= '0;
                            end
                            SFENCE_VMA: begin
                                state_q     <= TLB;
                                tlb_flush_o <= 1'b1;
                            end
                            default: begin
                                state_q          <= REDIRECT;
                                commit_ack_o     <= 1'b1;
                                flush_pipe_o     <= 1'b1;
                                redirect_valid_o <= 1'b1;
                                redirect_pc_o    <= pc_q + PC_STEP;
                            end
                        endcase
                    end
                end

                DFLUSH: begin
                    // An ack on the expiry cycle takes priority over the timeout
                    if (dcache_flush_ack_i || cnt_expire_c) begin
                        state_q        <= IFLUSH;
                        dcache_flush_o <= 1'b0;
                        icache_flush_o <= 1'b1;
                        flush_err_o    <= !dcache_flush_ack_i;
                        cnt_q          <= '0;
                    end else begin
                        cnt_q <= cnt_inc_c;
                    end
                end

                IFLUSH, TLB: begin
                    state_q          <= REDIRECT;
                    commit_ack_o     <= 1'b1;
                    flush_pipe_o     <= 1'b1;
                    redirect_valid_o <= 1'b1;
                    redirect_pc_o    <= pc_q + PC_STEP;
                end

                WAIT_IRQ: begin
                    if (irq_pending_i) begin
                        state_q          <= REDIRECT;
                        commit_ack_o     <= 1'b1;
                        flush_pipe_o     <= 1'b1;
                        redirect_valid_o <= 1'b1;
                        redirect_pc_o    <= pc_q + PC_STEP;
                    end
                end

                REDIRECT: begin
                    state_q      <= IDLE;
                    busy_o       <= 1'b0;
                    halt_fetch_o <= 1'b0;
                end

                default: begin
                    state_q        <= IDLE;
                    busy_o         <= 1'b0;
                    halt_fetch_o   <= 1'b0;
                    dcache_flush_o <= 1'b0;
                    cnt_q          <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fence_seq_ctrl.sv
// tb_fence_seq_ctrl: directed bench for fence_seq_ctrl with a scoreboard of
// expected pulse-output events checked by an independent monitor.

module tb_fence_seq_ctrl;
    import fence_seq_ctrl_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned TMO  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            commit_valid;
    fu_op_t          commit_op;
    logic [XLEN-1:0] commit_pc;
    logic            commit_ack;
    logic            busy;
    logic            halt_fetch;
    logic            sb_empty;
    logic            dflush;
    logic            dflush_ack;
    logic            iflush;
    logic            tlb_flush;
    logic            irq;
    logic            flush_pipe;
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            flush_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int dflush_cycles = 0;

    typedef struct {
        int              cyc;
        bit              ack;
        bit              icf;
        bit              tlb;
        bit              err;
        logic [XLEN-1:0] rpc;
    } exp_t;

    exp_t sbq[$];

    fence_seq_ctrl #(
        .DFLUSH_TIMEOUT (TMO),
        .XLEN           (XLEN)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .commit_valid_i     (commit_valid),
        .commit_op_i        (commit_op),
        .commit_pc_i        (commit_pc),
        .commit_ack_o       (commit_ack),
        .busy_o             (busy),
        .halt_fetch_o       (halt_fetch),
        .sb_empty_i         (sb_empty),
        .dcache_flush_o     (dflush),
        .dcache_flush_ack_i (dflush_ack),
        .icache_flush_o     (iflush),
        .tlb_flush_o        (tlb_flush),
        .irq_pending_i      (irq),
        .flush_pipe_o       (flush_pipe),
        .redirect_valid_o   (redir_valid),
        .redirect_pc_o      (redir_pc),
        .flush_err_o        (flush_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle with a pulse output must match the next expected event
    always @(negedge clk) begin
        exp_t e;
        if (dflush) dflush_cycles = dflush_cycles + 1;
        if (commit_ack || iflush || tlb_flush || flush_err || flush_pipe || redir_valid) begin
            checks = checks + 1;
            if (sbq.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_event cyc=%0d ack=%b icf=%b tlb=%b err=%b pipe=%b rv=%b pc=%h",
                         cyc, commit_ack, iflush, tlb_flush, flush_err, flush_pipe, redir_valid, redir_pc);
            end else begin
                e = sbq.pop_front();
                if (cyc != e.cyc || commit_ack != e.ack || flush_pipe != e.ack ||
                    redir_valid != e.ack || iflush != e.icf || tlb_flush != e.tlb ||
                    flush_err != e.err || redir_pc != e.rpc || !busy || !halt_fetch) begin
                    errors = errors + 1;
                    $display("FAIL event got cyc=%0d ack=%b pipe=%b rv=%b icf=%b tlb=%b err=%b pc=%h busy=%b halt=%b need cyc=%0d ack=%b icf=%b tlb=%b err=%b pc=%h busy=1 halt=1",
                             cyc, commit_ack, flush_pipe, redir_valid, iflush, tlb_flush, flush_err,
                             redir_pc, busy, halt_fetch, e.cyc, e.ack, e.icf, e.tlb, e.err, e.rpc);
                end
            end
        end
    end

    task automatic push(input int c, input bit ack, input bit icf, input bit tlb,
                        input bit err, input logic [XLEN-1:0] rpc);
        exp_t e;
        e.cyc = c; e.ack = ack; e.icf = icf; e.tlb = tlb; e.err = err; e.rpc = rpc;
        sbq.push_back(e);
    endtask

    // Present an op at a negedge; t0 is the cycle count there, the k-th cycle
    // after the accept edge is observed with cyc == t0 + k
    task automatic present(input fu_op_t op, input logic [XLEN-1:0] pc, output int t0);
        @(negedge clk);
        commit_valid = 1'b1;
        commit_op    = op;
        commit_pc    = pc;
        t0           = cyc;
    endtask

    // Hold commit_valid until the ack is seen, bounded
    task automatic wait_ack(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (commit_ack) seen = 1'b1;
        end
        commit_valid = 1'b0;
        if (!seen) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL ack_timeout got no ack in %0d cycles need ack", budget);
        end
    endtask

    task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] need);
        checks = checks + 1;
        if (got !== need) begin
            errors = errors + 1;
            $display("FAIL %s got %h need %h", name, got, need);
        end
    endtask

    function automatic logic [XLEN-1:0] out_or();
        return redir_pc | XLEN'({commit_ack, busy, halt_fetch, dflush, iflush,
                                 tlb_flush, flush_pipe, redir_valid, flush_err});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int bad;

        rst_n        = 1'b0;
        commit_valid = 1'b0;
        commit_op    = NOP;
        commit_pc    = '0;
        sb_empty     = 1'b1;
        dflush_ack   = 1'b0;
        irq          = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs_zero", out_or(), '0);
        rst_n = 1'b1;

        // Non-serialising op is ignored
        @(negedge clk);
        commit_valid = 1'b1;
        commit_op    = CSRRW;
        commit_pc    = 32'h0000_0040;
        repeat (4) @(negedge clk);
        check("other_op_not_busy", XLEN'({busy, halt_fetch}), '0);
        commit_valid = 1'b0;

        // FENCE with store buffer busy for 5 drain cycles
        dflush_cycles = 0;
        sb_empty = 1'b0;
        present(FENCE, 32'h8000_0000, t0);
        push(t0 + 7, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0004);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!halt_fetch || !busy) bad++;
        end
        check("fence_halt_during_drain", XLEN'(bad), '0);
        sb_empty = 1'b1;
        wait_ack(10);
        check("fence_no_dflush", XLEN'(dflush_cycles), '0);

        // FENCE_I, ack in third DFLUSH cycle
        dflush_cycles = 0;
        present(FENCE_I, 32'h0000_0100, t0);
        push(t0 + 5, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        push(t0 + 6, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0104);
        repeat (4) @(negedge clk);
        dflush_ack = 1'b1;
        @(negedge clk);
        dflush_ack = 1'b0;
        wait_ack(10);
        check("fencei_dflush_cycles", XLEN'(dflush_cycles), 32'd3);

        // FENCE_I with no ack: timeout after 8 DFLUSH cycles
        dflush_cycles = 0;
        present(FENCE_I, 32'h0000_0200, t0);
        push(t0 + 10, 1'b0, 1'b1, 1'b0, 1'b1, '0);
        push(t0 + 11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0204);
        wait_ack(20);
        check("timeout_dflush_cycles", XLEN'(dflush_cycles), 32'd8);

        // FENCE_I with ack on the 8th (expiry) DFLUSH cycle: no error
        dflush_cycles = 0;
        present(FENCE_I, 32'h0000_0300, t0);
        push(t0 + 10, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        push(t0 + 11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0304);
        repeat (9) @(negedge clk);
        dflush_ack = 1'b1;
        @(negedge clk);
        dflush_ack = 1'b0;
        wait_ack(10);
        check("ack_at_expiry_dflush_cycles", XLEN'(dflush_cycles), 32'd8);

        // SFENCE_VMA at the top of the address space, then back-to-back FENCE
        present(SFENCE_VMA, 32'hFFFF_FFFC, t0);
        push(t0 + 2, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        push(t0 + 3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
        wait_ack(10);
        check("sfence_ack_cycle", XLEN'(cyc), XLEN'(t0 + 3));
        commit_valid = 1'b1;
        commit_op    = FENCE;
        commit_pc    = 32'h0000_0040;
        push(t0 + 6, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0044);
        wait_ack(10);

        // WFI, interrupt raised in the 20th waiting cycle
        present(WFI, 32'h0000_0400, t0);
`ifdef FENCE_SEQ_WFI_NOP_EN
        push(t0 + 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0404);
        wait_ack(10);
`else
        push(t0 + 21, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0404);
        repeat (20) @(negedge clk);
        irq = 1'b1;
        wait_ack(10);
        irq = 1'b0;
`endif

        // WFI with interrupt already pending still spends one waiting cycle
        irq = 1'b1;
        present(WFI, 32'h0000_0500, t0);
`ifdef FENCE_SEQ_WFI_NOP_EN
        push(t0 + 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0504);
`else
        push(t0 + 2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0504);
`endif
        wait_ack(10);
        irq = 1'b0;

        // Reset in the middle of DFLUSH
        present(FENCE_I, 32'h0000_0600, t0);
        repeat (3) @(negedge clk);
        check("dflush_before_reset", XLEN'(dflush), 32'd1);
        rst_n        = 1'b0;
        commit_valid = 1'b0;
        @(negedge clk);
        check("mid_seq_reset_outputs_zero", out_or(), '0);
        rst_n = 1'b1;

        // Normal FENCE after the reset
        present(FENCE, 32'h0000_0700, t0);
        push(t0 + 2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0704);
        wait_ack(10);
        @(negedge clk);
        check("idle_after_fence", XLEN'({busy, halt_fetch}), '0);

        // All expected events consumed
        repeat (5) @(negedge clk);
        check("scoreboard_drained", XLEN'(sbq.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
